// File: rtl/btb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btb_ctrl_pkg
// Description : Shared types for the BTB update controller: the queued update
//               record and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package btb_ctrl_pkg;

    localparam int PC_W = 32;

    // One resolved-branch update as it travels through the queue
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            taken;
    } btb_update_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } btbc_state_t;

endpackage
`default_nettype wire

// File: rtl/btb_update_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : btb_update_controller_if
// Description : Requester handshakes, flush request, BTB write-port drive and
//               status signals of the BTB update controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface btb_update_controller_if #(
    parameter int FIFO_DEPTH = 4
);
    import btb_ctrl_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // execute-stage requester
    logic            exe_valid;
    logic [PC_W-1:0] exe_pc;
    logic [PC_W-1:0] exe_target;
    logic            exe_taken;
    logic            exe_ready;

    // decode-stage requester
    logic            dec_valid;
    logic [PC_W-1:0] dec_pc;
    logic [PC_W-1:0] dec_target;
    logic            dec_taken;
    logic            dec_ready;

    logic            flush_req;

    // BTB write port
    logic            btb_write;
    logic [PC_W-1:0] btb_new_pc;
    logic [PC_W-1:0] btb_data;
    logic            btb_branch_taken;
    logic            btb_reset;

    // status
    logic             busy;
    logic [CNT_W-1:0] fifo_count;

    // pipeline / environment side
    modport master (
        output exe_valid, exe_pc, exe_target, exe_taken,
        output dec_valid, dec_pc, dec_target, dec_taken,
        output flush_req,
        input  exe_ready, dec_ready,
        input  btb_write, btb_new_pc, btb_data, btb_branch_taken, btb_reset,
        input  busy, fifo_count
    );

    // controller side
    modport slave (
        input  exe_valid, exe_pc, exe_target, exe_taken,
        input  dec_valid, dec_pc, dec_target, dec_taken,
        input  flush_req,
        output exe_ready, dec_ready,
        output btb_write, btb_new_pc, btb_data, btb_branch_taken, btb_reset,
        output busy, fifo_count
    );

endinterface
`default_nettype wire

// File: rtl/btb_update_fifo.sv
`default_nettype none
// ============================================================================
// Module      : btb_update_fifo
// Description : Update queue with two ordered write ports (w0 before w1), one
//               read port, occupancy count, and a synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_update_fifo
    import btb_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    input  wire logic                          i_clear,
    input  wire logic                          i_push0,
    input  wire btb_update_t                   i_data0,
    input  wire logic                          i_push1,
    input  wire btb_update_t                   i_data1,
    input  wire logic                          i_pop,
    output btb_update_t                        o_head,
    output logic [$clog2(FIFO_DEPTH):0]        o_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    btb_update_t      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_push0;
    logic             w_push1;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr1_addr;
    logic [PTR_W-1:0] w_wr_adv;

    // Clear wins over everything; w1 lands behind w0 when both are written
    always_comb begin
        w_push0    = i_push0 & ~i_clear;
        w_push1    = i_push1 & ~i_clear;
        w_pop      = i_pop & ~i_clear & (r_count != '0);
        w_wr1_addr = w_push0 ? (r_wr_ptr + c_ptr_one) : r_wr_ptr;
        w_wr_adv   = PTR_W'(w_push0) + PTR_W'(w_push1);
    end

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (w_push0) r_mem[r_wr_ptr]   <= i_data0;
        if (w_push1) r_mem[w_wr1_addr] <= i_data1;
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_wr_adv;
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + CNT_W'(w_push0) + CNT_W'(w_push1) - CNT_W'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/btb_update_controller.sv
`default_nettype none
// ============================================================================
// Module      : btb_update_controller
// Description : Arbitrates execute/decode branch updates into a small queue,
//               drains one update per cycle onto the BTB write port, and
//               sequences BTB flushes after reset and on request.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_update_controller
    import btb_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic               btbc_clk,
    input  wire logic               btbc_reset_n,
    btb_update_controller_if.slave  bus
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  c_depth      = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  c_one        = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_two        = CNT_W'(2);
    localparam logic [FCNT_W-1:0] c_flush_last = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FCNT_W-1:0] c_fcnt_one   = FCNT_W'(1);

    btbc_state_t       r_state;
    btbc_state_t       w_state_nxt;
    logic [FCNT_W-1:0] r_flush_cnt;
    logic [FCNT_W-1:0] w_flush_cnt_nxt;

    logic              r_btb_write;
    btb_update_t       r_btb_upd;

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_free;
    logic              w_accept_ok;
    logic              w_exe_ready;
    logic              w_dec_ready;
    logic              w_pop;
    btb_update_t       w_head;
    btb_update_t       w_exe_upd;
    btb_update_t       w_dec_upd;

    // State register; reset lands in FLUSH so the BTB is always cleared first
    always_ff @(posedge btbc_clk) begin
        if (!btbc_reset_n) begin
            r_state     <= FLUSH;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Next state: a flush request (re)starts the flush window from zero
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        if (bus.flush_req) begin
            w_state_nxt     = FLUSH;
            w_flush_cnt_nxt = '0;
        end else if (r_state == FLUSH) begin
            if (r_flush_cnt == c_flush_last) begin
                w_state_nxt     = RUN;
                w_flush_cnt_nxt = '0;
            end else begin
                w_flush_cnt_nxt = r_flush_cnt + c_fcnt_one;
            end
        end
    end

    // Accept/drain decisions; free space ignores a same-cycle pop on purpose
    always_comb begin
        w_free      = c_depth - w_count;
        w_accept_ok = (r_state == RUN) && !bus.flush_req;
        w_exe_ready = w_accept_ok && (w_free >= c_one);
        w_dec_ready = w_accept_ok &&
                      ((w_free >= c_two) || ((w_free == c_one) && !bus.exe_valid));
        w_pop       = w_accept_ok && (w_count != '0);
        w_exe_upd   = '{pc: bus.exe_pc, target: bus.exe_target, taken: bus.exe_taken};
        w_dec_upd   = '{pc: bus.dec_pc, target: bus.dec_target, taken: bus.dec_taken};
    end

    btb_update_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (btbc_clk),
        .rst_n   (btbc_reset_n),
        .i_clear (bus.flush_req),
        .i_push0 (bus.exe_valid && w_exe_ready),
        .i_data0 (w_exe_upd),
        .i_push1 (bus.dec_valid && w_dec_ready),
        .i_data1 (w_dec_upd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Register the popped head onto the BTB port; data holds when idle
    always_ff @(posedge btbc_clk) begin
        if (!btbc_reset_n) begin
            r_btb_write <= 1'b0;
            r_btb_upd   <= '0;
        end else begin
            r_btb_write <= w_pop;
            if (w_pop) r_btb_upd <= w_head;
        end
    end

    assign bus.exe_ready        = w_exe_ready;
    assign bus.dec_ready        = w_dec_ready;
    assign bus.btb_write        = r_btb_write;
    assign bus.btb_new_pc       = r_btb_upd.pc;
    assign bus.btb_data         = r_btb_upd.target;
    assign bus.btb_branch_taken = r_btb_upd.taken;
    // Held low while reset is asserted; the flush proper begins on release
    assign bus.btb_reset        = (r_state == FLUSH) && btbc_reset_n;
    assign bus.busy             = (w_count != '0) || (r_state == FLUSH);
    assign bus.fifo_count       = w_count;

endmodule
`default_nettype wire
